// File: rtl/hough_pkg.sv
// Shared types for the edge-point / Hough voting path: point record and helpers.
package hough_pkg;

    localparam int COORD_W = 8;
    localparam int POINT_W = 24;

    // One edge point as it travels from the extractor to the Hough voter.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [7:0]         mag;
    } point_t;

    // Increment an 8-bit value, sticking at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_point_fifo.sv
// Synchronous first-word-fall-through FIFO of point records.
// The head entry is held in a register so data_o never glitches and keeps
// its last value while the FIFO is empty.
module edge_point_fifo
    import hough_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  point_t        data_i,
    input  logic          pop_i,
    output point_t        data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_CNT = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_CNT  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    point_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   remain_s;
    point_t        head_q, head_d;
    logic          pop_ok_s;
    logic          push_ok_s;

    // Pop only a real entry; push into a full FIFO only when a pop frees a slot.
    always_comb begin
        pop_ok_s  = pop_i & (count_q != ZERO_CNT);
        push_ok_s = push_i & ((count_q != FULL_CNT) | pop_ok_s);
    end

    // Next pointers, occupancy and head-of-queue register contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        // Entries left after this cycle's pop, before this cycle's push.
        remain_s = count_q - {{AW{1'b0}}, pop_ok_s};
        if (count_d == ZERO_CNT) begin
            head_d = head_q;
        end else if (remain_s == ZERO_CNT) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= ZERO_CNT;
            head_q   <= '{x: 8'd0, y: 8'd0, mag: 8'd0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign data_o  = head_q;
    assign empty_o = (count_q == ZERO_CNT);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

endmodule

// File: rtl/edge_point_extract.sv
// Edge point extractor: tracks raster position of the edge-magnitude stream,
// thresholds it away from the image border and queues {x,y,mag} points for
// the Hough voter. The pixel stream is never stalled; points that find the
// queue full are dropped and counted per frame.
module edge_point_extract
    import hough_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int BORDER = 2
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [7:0] PixelIn,
    input  logic       FrameIn,
    input  logic       LineIn,
    input  logic [7:0] Width,
    input  logic [7:0] Height,
    input  logic [7:0] Threshold,
    output logic [7:0] PointX,
    output logic [7:0] PointY,
    output logic [7:0] PointMag,
    output logic       PointValid,
    input  logic       PointReady,
    output logic       Overflow,
    output logic [7:0] DropCount
);

    localparam logic [8:0] BORDER9 = 9'(BORDER);

    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       armed_q, armed_d;
    logic [7:0] cur_x_s, cur_y_s;
    logic       qual_s;

    point_t     s1_point_q;
    logic       s1_qual_q;
    logic       s1_frame_q;

    logic       ovf_q, ovf_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    point_t     head_s;
    logic       empty_s;
    logic       full_s;
    logic [AW:0] count_s;
    logic       fifo_unused_s;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;

    // Position of the pixel on the bus this cycle and the counters for the next one.
    always_comb begin
        cur_x_s = x_q;
        cur_y_s = y_q;
        x_d     = sat_inc8(x_q);
        y_d     = y_q;
        armed_d = armed_q;
        if (FrameIn) begin
            cur_x_s = 8'd0;
            cur_y_s = 8'd0;
            x_d     = 8'd1;
            y_d     = 8'd0;
            armed_d = 1'b1;
        end else if (LineIn) begin
            cur_x_s = 8'd0;
            cur_y_s = sat_inc8(y_q);
            x_d     = 8'd1;
            y_d     = sat_inc8(y_q);
        end else begin
            cur_x_s = x_q;
            cur_y_s = y_q;
        end
    end

    // A pixel qualifies when armed, strictly above threshold and inside the border window.
    // Bounds use x + BORDER < Width in 9 bits so tiny images never underflow.
    always_comb begin
        qual_s = armed_d
               & (PixelIn > Threshold)
               & ({1'b0, cur_x_s} >= BORDER9)
               & (({1'b0, cur_x_s} + BORDER9) < {1'b0, Width})
               & ({1'b0, cur_y_s} >= BORDER9)
               & (({1'b0, cur_y_s} + BORDER9) < {1'b0, Height});
    end

    // Raster counters and arming flag.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            armed_q <= armed_d;
        end
    end

    // Stage 1: register the candidate point so the FIFO sees it one cycle later.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            s1_point_q <= '{x: 8'd0, y: 8'd0, mag: 8'd0};
            s1_qual_q  <= 1'b0;
            s1_frame_q <= 1'b0;
        end else begin
            s1_point_q <= '{x: cur_x_s, y: cur_y_s, mag: PixelIn};
            s1_qual_q  <= qual_s;
            s1_frame_q <= FrameIn;
        end
    end

    // Handshake with the consumer and the drop decision for the stage-1 point.
    always_comb begin
        pop_s  = ~empty_s & PointReady;
        push_s = s1_qual_q & (~full_s | pop_s);
        drop_s = s1_qual_q & full_s & ~pop_s;
    end

    // Per-frame drop statistics; a frame start restarts them with this cycle's drop.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (s1_frame_q) begin
            ovf_d      = drop_s;
            drop_cnt_d = {7'd0, drop_s};
        end else if (drop_s) begin
            ovf_d      = 1'b1;
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end else begin
            ovf_d      = ovf_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop statistics registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    edge_point_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (nReset),
        .push_i  (push_s),
        .data_i  (s1_point_q),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .count_o (count_s)
    );

    // Occupancy is exposed for the voter's reuse of the FIFO; not needed here.
    assign fifo_unused_s = ^count_s;

    assign PointX     = head_s.x;
    assign PointY     = head_s.y;
    assign PointMag   = head_s.mag;
    assign PointValid = ~empty_s;
    assign Overflow   = ovf_q;
    assign DropCount  = drop_cnt_q;

endmodule

// File: tb/tb_edge_point_extract.sv
// Randomized + directed bench for edge_point_extract against a queue-based
// reference model of the point stream.
module tb_edge_point_extract;

    logic       Clk = 1'b0;
    logic       nReset = 1'b1;
    logic [7:0] PixelIn = 8'd0;
    logic       FrameIn = 1'b0;
    logic       LineIn = 1'b0;
    logic [7:0] Width = 8'd0;
    logic [7:0] Height = 8'd0;
    logic [7:0] Threshold = 8'd0;
    logic [7:0] PointX, PointY, PointMag, DropCount;
    logic       PointValid, Overflow;
    logic       PointReady = 1'b0;

    always #5 Clk = ~Clk;

    edge_point_extract dut (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .Width(Width), .Height(Height), .Threshold(Threshold),
        .PointX(PointX), .PointY(PointY), .PointMag(PointMag),
        .PointValid(PointValid), .PointReady(PointReady),
        .Overflow(Overflow), .DropCount(DropCount)
    );

    typedef struct {
        int x;
        int y;
        int m;
    } pt_t;

    // reference model state
    pt_t q[$];
    pt_t s1p;
    pt_t last_head;
    bit  s1q, s1f, marmed;
    int  mx, my, movf, mdc;

    int n_checks = 0;
    int n_errors = 0;
    int seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        s1q = 0; s1f = 0; marmed = 0;
        s1p = '{0, 0, 0};
        last_head = '{0, 0, 0};
        mx = 0; my = 0; movf = 0; mdc = 0;
    endtask

    // Drive one pixel at the negedge, advance the model at the posedge, check at +1.
    task automatic step(input int pix, input bit fr, input bit ln, input bit rdy);
        int cx, cy, sz, w, h, thr;
        bit an, ql, pop, drop;
        pt_t exp_pt;
        PixelIn = pix[7:0]; FrameIn = fr; LineIn = ln; PointReady = rdy;
        if (PointValid && rdy) seen++;
        w = int'(Width); h = int'(Height); thr = int'(Threshold);
        @(posedge Clk);
        if (fr) begin cx = 0; cy = 0; end
        else if (ln) begin cx = 0; cy = (my >= 255) ? 255 : my + 1; end
        else begin cx = mx; cy = my; end
        an = marmed || fr;
        ql = an && (pix > thr) && (cx >= 2) && (cx + 2 < w) && (cy >= 2) && (cy + 2 < h);
        sz = q.size();
        pop = (sz != 0) && rdy;
        if (pop) void'(q.pop_front());
        drop = 0;
        if (s1q) begin
            if (sz < 16 || pop) q.push_back(s1p);
            else drop = 1;
        end
        if (s1f) begin movf = drop; mdc = drop; end
        else if (drop) begin movf = 1; if (mdc < 255) mdc++; end
        s1q = ql; s1f = fr; s1p = '{cx, cy, pix};
        if (fr) begin mx = 1; my = 0; end
        else if (ln) begin mx = 1; my = cy; end
        else mx = (mx >= 255) ? 255 : mx + 1;
        marmed = an;
        if (q.size() != 0) last_head = q[0];
        exp_pt = last_head;
        #1;
        check("valid", 32'(PointValid), 32'(q.size() != 0));
        check("x", 32'(PointX), 32'(exp_pt.x));
        check("y", 32'(PointY), 32'(exp_pt.y));
        check("mag", 32'(PointMag), 32'(exp_pt.m));
        check("ovf", 32'(Overflow), 32'(movf));
        check("dropcnt", 32'(DropCount), 32'(mdc));
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(PointValid), 32'd0);
        check("rst_x", 32'(PointX), 32'd0);
        check("rst_y", 32'(PointY), 32'd0);
        check("rst_mag", 32'(PointMag), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_dropcnt", 32'(DropCount), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
    endtask

    function automatic int pixval(input int mode, input int x, input int y);
        int idx;
        case (mode)
            0: return 0;
            1: return 255;
            2: return int'($urandom_range(0, 255));
            3: return (x == 3 && y == 2) ? 50 : 0;
            4: begin
                if (y == 2 && (x == 1 || x == 6)) return 60;
                if (x == 3 && y == 2) return 50;
                return 0;
            end
            5, 6: begin
                if (x >= 2 && x <= 13 && y >= 2) begin
                    idx = (y - 2) * 12 + (x - 2);
                    return (idx < ((mode == 5) ? 20 : 5)) ? 200 : 0;
                end
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    // rmode: 0 never ready, 1 always, 2 random, 3 ready from just after (2,2) onward
    task automatic send_frame(input int w, input int h, input int mode, input int rmode);
        bit rdy;
        Width = w[7:0]; Height = h[7:0];
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                case (rmode)
                    0: rdy = 0;
                    1: rdy = 1;
                    2: rdy = $urandom_range(0, 1);
                    default: rdy = (y > 2) || (y == 2 && x >= 3);
                endcase
                step(pixval(mode, x, y), (x == 0 && y == 0), (x == 0), rdy);
            end
            for (int b = 0; b < int'($urandom_range(0, 2)); b++)
                step(int'($urandom_range(0, 255)), 0, 0, (rmode == 0) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        int seen0;
        model_reset();
        do_reset();

        // No FrameIn yet: nothing may be emitted.
        Width = 8'd8; Height = 8'd8; Threshold = 8'd10;
        for (int i = 0; i < 30; i++) step(200, 0, 0, 1);
        check("noarm_valid", 32'(PointValid), 32'd0);
        check("noarm_drops", 32'(DropCount), 32'd0);

        // Single point at (3,2).
        Threshold = 8'd49; seen = 0;
        send_frame(8, 8, 3, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("frameA_pts", 32'(seen), 32'd1);

        // Border pixels and strict threshold compare: no new points.
        Threshold = 8'd50;
        send_frame(8, 8, 4, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("frameB_pts", 32'(seen), 32'd1);

        // Overflow: 20 points, no consumer.
        Threshold = 8'd100;
        send_frame(16, 16, 5, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("ovf_set", 32'(Overflow), 32'd1);
        check("ovf_drops", 32'(DropCount), 32'd4);
        check("ovf_valid", 32'(PointValid), 32'd1);

        // New frame clears the statistics but keeps the queued points.
        step(0, 1, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("clr_ovf", 32'(Overflow), 32'd0);
        check("clr_drops", 32'(DropCount), 32'd0);
        check("clr_valid", 32'(PointValid), 32'd1);

        // Full FIFO with a consumer and dense qualifying pixels: no drops.
        Threshold = 8'd0;
        send_frame(16, 16, 1, 3);
        check("full_nodrop", 32'(DropCount), 32'd0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1);
        check("drained", 32'(PointValid), 32'd0);

        // Reset with 5 entries queued.
        Threshold = 8'd100;
        send_frame(16, 16, 6, 0);
        check("pre_rst_valid", 32'(PointValid), 32'd1);
        do_reset();
        Threshold = 8'd10; Width = 8'd8; Height = 8'd8;
        seen0 = seen;
        for (int i = 0; i < 40; i++) step(200, 0, 0, 1);
        check("post_rst_pts", 32'(seen), 32'(seen0));
        send_frame(8, 8, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("resume_pts", 32'(seen - seen0), 32'd16);

        // Width below 2*BORDER qualifies nothing.
        Threshold = 8'd0; seen0 = seen;
        send_frame(3, 10, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("narrow_pts", 32'(seen), 32'(seen0));

        // Random frames, random thresholds and random back-pressure.
        for (int f = 0; f < 10; f++) begin
            Threshold = 8'($urandom_range(0, 255));
            send_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 2, 2);
        end
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
